axis_pattern_gen: RTL and testbench

//  Parametrised AXI4-Stream test-pattern source for datapath bring-up and DMA loopback checks.

---
 rtl/axis_pattern_gen_if.sv | 14 +
 rtl/axis_pattern_gen.sv | 157 +++++++++++++++
 tb/tb_axis_pattern_gen.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pattern_gen_if.sv
// AXI4-Stream bundle for the pattern generator: data, byte enables, valid/last
// from the source, ready from the sink.
interface axis_pattern_gen_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_pattern_gen.sv
// AXI4-Stream test-pattern source: a run of fixed-length packets separated by an
// idle gap, with INCR / BYTE_RAMP / LFSR / CONST payloads and boundary abort.
module axis_pattern_gen #(
  parameter int DATA_WIDTH   = 64,
  parameter int LENGTH_WIDTH = 16,
  parameter int PKT_WIDTH    = 16,
  parameter int GAP_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [LENGTH_WIDTH-1:0] i_length,
  input  logic [PKT_WIDTH-1:0]    i_pkt_num,
  input  logic [GAP_WIDTH-1:0]    i_gap,
  input  logic [1:0]              i_mode,
  input  logic [31:0]             i_seed,
  axis_pattern_gen_if.master      m_axis,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [PKT_WIDTH-1:0]    o_pkt_cnt,
  output logic [1:0]              o_state
);
  // Stream handshake: a beat transfers on a rising clk edge where tvalid and
  // tready are both high; tvalid is a function of state only, never of tready,
  // and tdata/tkeep/tlast hold while tvalid is high and the beat is not taken.

  localparam int STRB = DATA_WIDTH / 8;
  localparam int BW   = LENGTH_WIDTH + 1;
  localparam logic [BW-1:0]        BEAT_ONE  = BW'(1);
  localparam logic [BW-1:0]        STRB_M1   = BW'(STRB - 1);
  localparam logic [BW-1:0]        STRB_BW   = BW'(STRB);
  localparam logic [7:0]           STRB_B    = 8'(STRB % 256);
  localparam logic [PKT_WIDTH-1:0] PKT_ONE   = PKT_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0] GAP_ONE   = GAP_WIDTH'(1);
  localparam logic [31:0]          LFSR_TAPS = 32'h8020_0003;

  localparam logic [1:0] M_INCR  = 2'd0;
  localparam logic [1:0] M_RAMP  = 2'd1;
  localparam logic [1:0] M_LFSR  = 2'd2;
  localparam logic [1:0] M_CONST = 2'd3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2} state_t;

  state_t                r_state, w_next;
  logic [BW-1:0]         r_beats, r_tail, r_beat_idx;
  logic [PKT_WIDTH-1:0]  r_pkt_num, r_pkt_cnt;
  logic [GAP_WIDTH-1:0]  r_gap, r_gap_cnt;
  logic [1:0]            r_mode;
  logic [31:0]           r_seed, r_ctr, r_lfsr;
  logic [7:0]            r_ramp;
  logic                  r_abort, r_done;

  logic                  w_hs, w_last_beat, w_final, w_abort, w_start_ok;
  logic [BW-1:0]         w_len_ext;

  assign w_len_ext   = {1'b0, i_length};
  assign w_start_ok  = i_start && (i_length != '0) && (i_pkt_num != '0);
  assign w_hs        = (r_state == S_SEND) && m_axis.tready;
  assign w_last_beat = (r_beat_idx == r_beats - BEAT_ONE);
  assign w_final     = (r_pkt_cnt + PKT_ONE == r_pkt_num);
  assign w_abort     = r_abort || i_abort;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok) w_next = S_SEND;
      S_SEND: begin
        if (w_hs && w_last_beat) begin
          if (w_final || w_abort) w_next = S_IDLE;
          else if (r_gap != '0)   w_next = S_GAP;
          else                    w_next = S_SEND;
        end
      end
      S_GAP: begin
        if (w_abort)                 w_next = S_IDLE;
        else if (r_gap_cnt == GAP_ONE) w_next = S_SEND;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beats <= '0; r_tail <= '0; r_beat_idx <= '0;
      r_pkt_num <= '0; r_pkt_cnt <= '0; r_gap <= '0; r_gap_cnt <= '0;
      r_mode <= '0; r_seed <= '0; r_ctr <= '0; r_lfsr <= '0; r_ramp <= '0;
      r_abort <= 1'b0; r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_start_ok) begin
          r_beats    <= (w_len_ext + STRB_M1) / STRB_BW;
          r_tail     <= w_len_ext % STRB_BW;
          r_pkt_num  <= i_pkt_num;
          r_gap      <= i_gap;
          r_mode     <= i_mode;
          r_seed     <= i_seed;
          r_ctr      <= i_seed;
          r_lfsr     <= (i_seed == 32'h0) ? 32'h1 : i_seed;
          r_pkt_cnt  <= '0;
          r_beat_idx <= '0;
          r_ramp     <= '0;
          r_abort    <= 1'b0;
        end
      end else if (i_abort) begin
        r_abort <= 1'b1;
      end
      // Generator state moves only on an accepted beat and carries across packets.
      if (w_hs) begin
        r_ctr      <= r_ctr + 32'd1;
        r_lfsr     <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
        r_ramp     <= r_ramp + STRB_B;
        r_beat_idx <= r_beat_idx + BEAT_ONE;
        if (w_last_beat) begin
          r_beat_idx <= '0;
          r_ramp     <= '0;
          r_pkt_cnt  <= r_pkt_cnt + PKT_ONE;
          r_gap_cnt  <= r_gap;
        end
      end
      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt - GAP_ONE;
      if (r_state != S_IDLE && w_next == S_IDLE) begin
        r_done  <= 1'b1;
        r_abort <= 1'b0;
      end
    end
  end

  always_comb begin
    m_axis.tdata  = '0;
    m_axis.tkeep  = '0;
    m_axis.tvalid = (r_state == S_SEND);
    m_axis.tlast  = (r_state == S_SEND) && w_last_beat;
    o_busy        = (r_state != S_IDLE);
    o_done        = r_done;
    o_pkt_cnt     = r_pkt_cnt;
    o_state       = r_state;
    if (r_state == S_SEND) begin
      for (int k = 0; k < STRB; k++) begin
        case (r_mode)
          M_INCR:  m_axis.tdata[k*8 +: 8] = (k < 4) ? r_ctr[(k%4)*8 +: 8] : 8'h00;
          M_RAMP:  m_axis.tdata[k*8 +: 8] = r_ramp + 8'(k);
          M_LFSR:  m_axis.tdata[k*8 +: 8] = r_lfsr[(k%4)*8 +: 8];
          M_CONST: m_axis.tdata[k*8 +: 8] = r_seed[(k%4)*8 +: 8];
          default: m_axis.tdata[k*8 +: 8] = 8'h00;
        endcase
        m_axis.tkeep[k] = !w_last_beat || (r_tail == '0) || (BW'(k) < r_tail);
      end
    end
  end
endmodule

// File: tb/tb_axis_pattern_gen.sv
// Directed bench for axis_pattern_gen (64-bit): packet shape, data modes, gaps,
// stalls, abort and reset behaviour against hand-computed beats.
module tb_axis_pattern_gen;
  localparam int DW = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_abort;
  logic [15:0] i_length, i_pkt_num;
  logic [7:0]  i_gap;
  logic [1:0]  i_mode;
  logic [31:0] i_seed;
  logic        o_busy, o_done;
  logic [15:0] o_pkt_cnt;
  logic [1:0]  o_state;

  axis_pattern_gen_if #(.DATA_WIDTH(DW)) bus ();

  axis_pattern_gen #(.DATA_WIDTH(DW), .LENGTH_WIDTH(16), .PKT_WIDTH(16), .GAP_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_length(i_length),
    .i_pkt_num(i_pkt_num), .i_gap(i_gap), .i_mode(i_mode), .i_seed(i_seed),
    .m_axis(bus), .o_busy(o_busy), .o_done(o_done), .o_pkt_cnt(o_pkt_cnt), .o_state(o_state)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_d[$];
  logic [7:0]    obs_k[$];
  logic          obs_l[$];
  int            obs_gap[$];
  int            unstable, done_delta, done_pkt;
  logic          timed_out, busy_at_done;

  // Start pulse, then scramble the config inputs to show they are not re-sampled.
  task automatic drive_start(input int len, input int pkts, input int gap,
                             input logic [1:0] mode, input logic [31:0] seed, input logic abort_too);
    @(posedge clk); #1;
    i_length = 16'(len); i_pkt_num = 16'(pkts); i_gap = 8'(gap);
    i_mode = mode; i_seed = seed; i_start = 1'b1; i_abort = abort_too;
    @(posedge clk); #1;
    i_start = 1'b0; i_abort = 1'b0;
    i_length = 16'd1; i_pkt_num = 16'd9; i_gap = 8'd7; i_mode = mode ^ 2'd1; i_seed = ~seed;
  endtask

  // Monitor: record accepted beats, idle gaps and stalls until o_done or the budget runs out.
  task automatic run_collect(input int max_cyc, input bit rnd, input int abort_after);
    int idle, last_c;
    bit in_gap, pend, arm;
    logic [DW-1:0] hd;
    logic [7:0] hk;
    logic hl;
    obs_d.delete(); obs_k.delete(); obs_l.delete(); obs_gap.delete();
    unstable = 0; timed_out = 1'b1; done_delta = -1; done_pkt = -1; busy_at_done = 1'b1;
    idle = 0; in_gap = 0; pend = 0; arm = 0; last_c = -100; hd = '0; hk = '0; hl = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (pend && (!bus.tvalid || bus.tdata !== hd || bus.tkeep !== hk || bus.tlast !== hl))
        unstable++;
      pend = 0;
      if (o_done) begin
        timed_out = 1'b0; done_delta = c - last_c; done_pkt = int'(o_pkt_cnt);
        busy_at_done = o_busy;
        break;
      end
      if (bus.tvalid) begin
        if (in_gap) begin obs_gap.push_back(idle); in_gap = 0; end
        if (bus.tready) begin
          obs_d.push_back(bus.tdata); obs_k.push_back(bus.tkeep); obs_l.push_back(bus.tlast);
          if (obs_d.size() - 1 == abort_after) arm = 1;
          if (bus.tlast) begin in_gap = 1; idle = 0; last_c = c; end
        end else begin
          pend = 1; hd = bus.tdata; hk = bus.tkeep; hl = bus.tlast;
        end
      end else if (in_gap) begin
        idle++;
      end
      @(posedge clk); #1;
      i_abort = arm; arm = 0;
      if (rnd) bus.tready = 1'($urandom_range(0, 1));
    end
    i_abort = 1'b0;
    bus.tready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (bus.tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %b want 0", bus.tvalid); end
    n_total++; if (bus.tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast: got %b want 0", bus.tlast); end
    n_total++; if (bus.tdata !== 64'h0) begin n_bad++; $display("FAIL reset_tdata: got %h want 0", bus.tdata); end
    n_total++; if (bus.tkeep !== 8'h00) begin n_bad++; $display("FAIL reset_tkeep: got %h want 00", bus.tkeep); end
    n_total++; if ({o_busy, o_done} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_done: got %b want 00", {o_busy, o_done}); end
    n_total++; if (o_pkt_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_pkt_cnt: got %0d want 0", o_pkt_cnt); end
    n_total++; if (o_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", o_state); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_incr_single();
    logic [7:0] ek[3];
    logic el[3];
    ek = '{8'hFF, 8'hFF, 8'h0F};
    el = '{1'b0, 1'b0, 1'b1};
    exp_q = '{64'd5, 64'd6, 64'd7};
    drive_start(20, 1, 0, 2'd0, 32'd5, 1'b0);
    n_total++; if ({bus.tvalid, o_busy} !== 2'b11) begin n_bad++; $display("FAIL start_latency: got %b want 11", {bus.tvalid, o_busy}); end
    run_collect(20, 1'b0, -1);
    n_total++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL t1_timeout: got %b want 0", timed_out); end
    n_total++; if (obs_d.size() != 3) begin n_bad++; $display("FAIL t1_beats: got %0d want 3", obs_d.size()); end
    for (int i = 0; i < 3 && i < obs_d.size(); i++) begin
      n_total++; if (obs_d[i] !== exp_q[i]) begin n_bad++; $display("FAIL t1_data[%0d]: got %h want %h", i, obs_d[i], exp_q[i]); end
      n_total++; if (obs_k[i] !== ek[i]) begin n_bad++; $display("FAIL t1_keep[%0d]: got %h want %h", i, obs_k[i], ek[i]); end
      n_total++; if (obs_l[i] !== el[i]) begin n_bad++; $display("FAIL t1_last[%0d]: got %b want %b", i, obs_l[i], el[i]); end
    end
    n_total++; if (done_delta != 1) begin n_bad++; $display("FAIL t1_done_delay: got %0d want 1", done_delta); end
    n_total++; if (busy_at_done !== 1'b0) begin n_bad++; $display("FAIL t1_busy_at_done: got %b want 0", busy_at_done); end
    n_total++; if (done_pkt != 1) begin n_bad++; $display("FAIL t1_pkt_cnt: got %0d want 1", done_pkt); end
    @(negedge clk);
    n_total++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL t1_done_width: got %b want 0", o_done); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e;
    drive_start(16, 3, 0, 2'd0, 32'd100, 1'b0);
    run_collect(30, 1'b0, -1);
    n_total++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL t2_timeout: got %b want 0", timed_out); end
    n_total++; if (obs_d.size() != 6) begin n_bad++; $display("FAIL t2_beats: got %0d want 6", obs_d.size()); end
    for (int i = 0; i < 6 && i < obs_d.size(); i++) begin
      e = 64'(100 + i);
      n_total++; if (obs_d[i] !== e) begin n_bad++; $display("FAIL t2_data[%0d]: got %h want %h", i, obs_d[i], e); end
      n_total++; if (obs_l[i] !== 1'(i % 2)) begin n_bad++; $display("FAIL t2_last[%0d]: got %b want %0d", i, obs_l[i], i % 2); end
      n_total++; if (obs_k[i] !== 8'hFF) begin n_bad++; $display("FAIL t2_keep[%0d]: got %h want FF", i, obs_k[i]); end
    end
    n_total++; if (obs_gap.size() != 2) begin n_bad++; $display("FAIL t2_gap_count: got %0d want 2", obs_gap.size()); end
    foreach (obs_gap[i]) begin
      n_total++; if (obs_gap[i] != 0) begin n_bad++; $display("FAIL t2_gap[%0d]: got %0d want 0", i, obs_gap[i]); end
    end
    n_total++; if (done_pkt != 3) begin n_bad++; $display("FAIL t2_pkt_cnt: got %0d want 3", done_pkt); end
    repeat (3) @(negedge clk);
    n_total++; if (o_pkt_cnt !== 16'd3) begin n_bad++; $display("FAIL t2_pkt_cnt_held: got %0d want 3", o_pkt_cnt); end
  endtask

  task automatic test_gap_stall();
    exp_q = '{64'h0000_0000_FFFF_FFFE, 64'h0000_0000_FFFF_FFFF, 64'h0};
    drive_start(8, 3, 4, 2'd0, 32'hFFFF_FFFE, 1'b0);
    run_collect(400, 1'b1, -1);
    n_total++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL t3_timeout: got %b want 0", timed_out); end
    n_total++; if (obs_d.size() != 3) begin n_bad++; $display("FAIL t3_beats: got %0d want 3", obs_d.size()); end
    for (int i = 0; i < 3 && i < obs_d.size(); i++) begin
      n_total++; if (obs_d[i] !== exp_q[i]) begin n_bad++; $display("FAIL t3_data[%0d]: got %h want %h", i, obs_d[i], exp_q[i]); end
      n_total++; if (obs_l[i] !== 1'b1) begin n_bad++; $display("FAIL t3_last[%0d]: got %b want 1", i, obs_l[i]); end
    end
    n_total++; if (obs_gap.size() != 2) begin n_bad++; $display("FAIL t3_gap_count: got %0d want 2", obs_gap.size()); end
    foreach (obs_gap[i]) begin
      n_total++; if (obs_gap[i] != 4) begin n_bad++; $display("FAIL t3_gap[%0d]: got %0d want 4", i, obs_gap[i]); end
    end
    n_total++; if (unstable != 0) begin n_bad++; $display("FAIL t3_stall_stable: got %0d want 0", unstable); end
    n_total++; if (done_pkt != 3) begin n_bad++; $display("FAIL t3_pkt_cnt: got %0d want 3", done_pkt); end
  endtask

  task automatic test_lfsr_const();
    exp_q = '{64'h0000_0001_0000_0001, 64'h8020_0003_8020_0003,
              64'hC030_0002_C030_0002, 64'h6018_0001_6018_0001};
    drive_start(32, 1, 0, 2'd2, 32'h0, 1'b0);
    run_collect(20, 1'b0, -1);
    n_total++; if (obs_d.size() != 4) begin n_bad++; $display("FAIL t4_lfsr_beats: got %0d want 4", obs_d.size()); end
    for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
      n_total++; if (obs_d[i] !== exp_q[i]) begin n_bad++; $display("FAIL t4_lfsr[%0d]: got %h want %h", i, obs_d[i], exp_q[i]); end
    end
    drive_start(24, 2, 1, 2'd3, 32'hA5A5_A5A5, 1'b0);
    run_collect(30, 1'b0, -1);
    n_total++; if (obs_d.size() != 6) begin n_bad++; $display("FAIL t4_const_beats: got %0d want 6", obs_d.size()); end
    foreach (obs_d[i]) begin
      n_total++; if (obs_d[i] !== 64'hA5A5_A5A5_A5A5_A5A5) begin n_bad++; $display("FAIL t4_const[%0d]: got %h want a5a5a5a5a5a5a5a5", i, obs_d[i]); end
      n_total++; if (obs_k[i] !== 8'hFF) begin n_bad++; $display("FAIL t4_const_keep[%0d]: got %h want FF", i, obs_k[i]); end
    end
    n_total++; if (obs_gap.size() != 1 || obs_gap[0] != 1) begin n_bad++; $display("FAIL t4_const_gap: got %0d entries want one of 1", obs_gap.size()); end
  endtask

  task automatic test_byte_ramp();
    logic [DW-1:0] e;
    logic [7:0] ek;
    exp_q.delete();
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < 38; b++) begin
        for (int k = 0; k < 8; k++) e[k*8 +: 8] = 8'((b * 8 + k) % 256);
        exp_q.push_back(e);
      end
    drive_start(300, 2, 0, 2'd1, 32'h1234_5678, 1'b0);
    run_collect(200, 1'b0, -1);
    n_total++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL t5_timeout: got %b want 0", timed_out); end
    n_total++; if (obs_d.size() != 76) begin n_bad++; $display("FAIL t5_beats: got %0d want 76", obs_d.size()); end
    for (int i = 0; i < 76 && i < obs_d.size(); i++) begin
      ek = ((i % 38) == 37) ? 8'h0F : 8'hFF;
      n_total++; if (obs_d[i] !== exp_q[i]) begin n_bad++; $display("FAIL t5_data[%0d]: got %h want %h", i, obs_d[i], exp_q[i]); end
      n_total++; if (obs_k[i] !== ek) begin n_bad++; $display("FAIL t5_keep[%0d]: got %h want %h", i, obs_k[i], ek); end
      n_total++; if (obs_l[i] !== ((i % 38) == 37)) begin n_bad++; $display("FAIL t5_last[%0d]: got %b", i, obs_l[i]); end
    end
  endtask

  task automatic test_abort();
    int extra;
    drive_start(16, 5, 2, 2'd0, 32'd0, 1'b0);
    run_collect(60, 1'b0, 2);
    n_total++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL t6_timeout: got %b want 0", timed_out); end
    n_total++; if (obs_d.size() != 4) begin n_bad++; $display("FAIL t6_beats: got %0d want 4", obs_d.size()); end
    for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
      n_total++; if (obs_d[i] !== 64'(i)) begin n_bad++; $display("FAIL t6_data[%0d]: got %h want %0d", i, obs_d[i], i); end
    end
    n_total++; if (done_pkt != 2) begin n_bad++; $display("FAIL t6_pkt_cnt: got %0d want 2", done_pkt); end
    extra = 0;
    repeat (8) begin @(negedge clk); if (bus.tvalid || o_busy) extra++; end
    n_total++; if (extra != 0) begin n_bad++; $display("FAIL t6_quiet_after: got %0d want 0", extra); end
  endtask

  task automatic test_abort_gap();
    drive_start(8, 4, 3, 2'd0, 32'd40, 1'b0);
    run_collect(40, 1'b0, 0);
    n_total++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL abort_gap_timeout: got %b want 0", timed_out); end
    n_total++; if (obs_d.size() != 1) begin n_bad++; $display("FAIL abort_gap_beats: got %0d want 1", obs_d.size()); end
    n_total++; if (done_pkt != 1) begin n_bad++; $display("FAIL abort_gap_pkt_cnt: got %0d want 1", done_pkt); end
  endtask

  task automatic test_start_abort_same();
    drive_start(8, 2, 0, 2'd0, 32'd7, 1'b1);
    run_collect(20, 1'b0, -1);
    n_total++; if (obs_d.size() != 2) begin n_bad++; $display("FAIL start_abort_beats: got %0d want 2", obs_d.size()); end
    n_total++; if (done_pkt != 2) begin n_bad++; $display("FAIL start_abort_pkt_cnt: got %0d want 2", done_pkt); end
  endtask

  task automatic test_zero_ignore();
    int act;
    drive_start(0, 3, 0, 2'd0, 32'd1, 1'b0);
    act = 0;
    repeat (5) begin @(negedge clk); if (bus.tvalid || o_busy || o_done) act++; end
    n_total++; if (act != 0) begin n_bad++; $display("FAIL zero_len_ignored: got %0d active cycles want 0", act); end
    drive_start(8, 0, 0, 2'd0, 32'd1, 1'b0);
    act = 0;
    repeat (5) begin @(negedge clk); if (bus.tvalid || o_busy || o_done) act++; end
    n_total++; if (act != 0) begin n_bad++; $display("FAIL zero_pkts_ignored: got %0d active cycles want 0", act); end
  endtask

  task automatic test_rst_mid_run();
    @(posedge clk); #1 bus.tready = 1'b0;
    drive_start(64, 1, 0, 2'd0, 32'd9, 1'b0);
    @(negedge clk);
    n_total++; if (bus.tvalid !== 1'b1 || bus.tdata !== 64'd9) begin n_bad++; $display("FAIL rst_pre_beat: got v=%b d=%h want v=1 d=9", bus.tvalid, bus.tdata); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_total++; if (bus.tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_tvalid: got %b want 0", bus.tvalid); end
    n_total++; if ({o_busy, o_done} !== 2'b00 || o_pkt_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_mid_status: got %b/%0d want 00/0", {o_busy, o_done}, o_pkt_cnt); end
    n_total++; if (bus.tdata !== 64'h0 || bus.tkeep !== 8'h00) begin n_bad++; $display("FAIL rst_mid_data: got %h/%h want 0/0", bus.tdata, bus.tkeep); end
    @(posedge clk); #1 rst = 1'b0; bus.tready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_length = '0; i_pkt_num = '0;
    i_gap = '0; i_mode = '0; i_seed = '0; bus.tready = 1'b1;
    test_reset();
    test_incr_single();
    test_back_to_back();
    test_gap_stall();
    test_lfsr_const();
    test_byte_ramp();
    test_abort();
    test_abort_gap();
    test_start_abort_same();
    test_zero_ignore();
    test_rst_mid_run();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1, "watchdog expired");
  end
endmodule
